// File: rtl/dsp48_mult_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package     : dsp48_mult_pkg
// Description : Shared types and helpers for dsp48_mult_scaled. Contains the
//               product-width helper and the shift/round/saturate function.
//               The function works on a wide fixed container. The caller
//               passes its own widths and uses only the low DOUT_WIDTH bits.
// Config      : DSP48_MULT_ROUND_EN - when defined, round half up before the
//               right shift. Otherwise the shift truncates toward -inf.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp48_mult_pkg;

   // Container width for products and results. PROD_WIDTH and DOUT_WIDTH
   // must stay below this value.
   localparam int MAX_W  = 128;
   // Two guard bits. They hold the sign of a signed product and the carry
   // out of the rounding add.
   localparam int CALC_W = MAX_W + 2;

   typedef struct packed {
      logic             sat;
      logic [MAX_W-1:0] value;
   } sat_res_t;

   function automatic int prod_width(input int w1, input int w2);
      return w1 + w2;
   endfunction

   // product: raw PROD_WIDTH-bit product, zero-extended into the container.
   // mode   : 1 = two's complement, 0 = unsigned.
   function automatic sat_res_t sat_shift(
      input logic [MAX_W-1:0] product,
      input logic             mode,
      input int               prod_w,
      input int               dout_w,
      input int               shift
   );
      logic signed [CALC_W-1:0] ext;
      logic signed [CALC_W-1:0] shifted;
      logic signed [CALC_W-1:0] hi;
      logic signed [CALC_W-1:0] lo;
      logic signed [CALC_W-1:0] one;
      sat_res_t                 res;

      one = 1;
      ext = {2'b00, product};
      // Sign-extend from bit prod_w-1. Shift the sign bit to the top, then
      // bring it back down with an arithmetic shift.
      if (mode) begin
         ext = (ext << (CALC_W - prod_w)) >>> (CALC_W - prod_w);
      end
`ifdef DSP48_MULT_ROUND_EN
      if (shift > 0) begin
         ext = ext + (one <<< (shift - 1));
      end
`endif
      // An unsigned value is non-negative in the container, so one
      // arithmetic shift serves both modes.
      shifted = ext >>> shift;

      if (mode) begin
         hi = (one <<< (dout_w - 1)) - one;
         lo = -(one <<< (dout_w - 1));
      end else begin
         hi = (one <<< dout_w) - one;
         lo = '0;
      end

      if (shifted > hi) begin
         res.sat   = 1'b1;
         res.value = hi[MAX_W-1:0];
      end else if (shifted < lo) begin
         res.sat   = 1'b1;
         res.value = lo[MAX_W-1:0];
      end else begin
         res.sat   = 1'b0;
         res.value = shifted[MAX_W-1:0];
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_delay.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_delay
// Description : Fixed-depth shift register with asynchronous active-low
//               reset. dout is din delayed by DEPTH clock cycles.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset; clears every stage
//               din   - WIDTH-bit input
//               dout  - WIDTH-bit output after DEPTH stages
// Parameters  : WIDTH (>=1), DEPTH (>=1)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_d [DEPTH];
   logic [WIDTH-1:0] stage_q [DEPTH];

   always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/dsp48_mult_scaled.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dsp48_mult_scaled
// Description : Pipelined signed/unsigned multiplier. The product is shifted
//               right by a fixed SHIFT, then saturated to DOUT_WIDTH. A flag
//               marks every clamped result.
//               Latency is IN_REGS + 1 + OUT_REGS cycles. It accepts one
//               sample per cycle and has no backpressure.
// Config      : DSP48_MULT_ROUND_EN - round half up before shifting.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               din1/din2  - operands
//               din_signed - 1 = two's complement, 0 = unsigned (per sample)
//               din_valid  - operands valid
//               dout       - scaled, saturated product
//               dout_valid - dout valid
//               dout_sat   - dout was clamped
// Limits      : IN_REGS >= 1, OUT_REGS >= 1, 0 <= SHIFT < PROD_WIDTH,
//               PROD_WIDTH and DOUT_WIDTH below dsp48_mult_pkg::MAX_W
// Revision    : 1.0 - initial release
// ============================================================================
module dsp48_mult_scaled
   import dsp48_mult_pkg::*;
#(
   parameter int DIN1_WIDTH = 16,
   parameter int DIN2_WIDTH = 16,
   parameter int DOUT_WIDTH = 32,
   parameter int SHIFT      = 0,
   parameter int IN_REGS    = 2,
   parameter int OUT_REGS   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DIN1_WIDTH-1:0] din1,
   input  logic [DIN2_WIDTH-1:0] din2,
   input  logic                  din_signed,
   input  logic                  din_valid,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  dout_sat
);

   localparam int PROD_WIDTH = prod_width(DIN1_WIDTH, DIN2_WIDTH);
   localparam int LATENCY    = IN_REGS + 1 + OUT_REGS;
   localparam int OP_W       = 1 + DIN1_WIDTH + DIN2_WIDTH;

   // ---------------------------------------------------------------- input
   // Invalid cycles load zeros, so the pipe stays clean and unused slots
   // carry a zero product with mode 0.
   logic [OP_W-1:0]       w_op_in;
   logic [OP_W-1:0]       w_op_out;
   logic                  w_mode;
   logic [DIN1_WIDTH-1:0] w_a;
   logic [DIN2_WIDTH-1:0] w_b;

   always_comb begin
      w_op_in = din_valid ? {din_signed, din1, din2} : '0;
   end

   pipe_delay #(
      .WIDTH (OP_W),
      .DEPTH (IN_REGS)
   ) u_in_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (w_op_in),
      .dout  (w_op_out)
   );

   assign {w_mode, w_a, w_b} = w_op_out;

   // -------------------------------------------------------------- product
   // The operands get one extra bit: a copy of the sign bit in signed mode,
   // or a zero in unsigned mode. One signed multiply then serves both
   // modes. The low PROD_WIDTH bits are exact in either case.
   logic signed [DIN1_WIDTH:0]   w_a_ext;
   logic signed [DIN2_WIDTH:0]   w_b_ext;
   logic signed [PROD_WIDTH-1:0] w_a_sx;
   logic signed [PROD_WIDTH-1:0] w_b_sx;
   logic [PROD_WIDTH-1:0]        product_d;
   logic [PROD_WIDTH-1:0]        product_q;
   logic                         mode_d;
   logic                         mode_q;

   always_comb begin
      w_a_ext   = {w_mode & w_a[DIN1_WIDTH-1], w_a};
      w_b_ext   = {w_mode & w_b[DIN2_WIDTH-1], w_b};
      w_a_sx    = PROD_WIDTH'(w_a_ext);
      w_b_sx    = PROD_WIDTH'(w_b_ext);
      product_d = w_a_sx * w_b_sx;
      mode_d    = w_mode;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         product_q <= '0;
         mode_q    <= 1'b0;
      end else begin
         product_q <= product_d;
         mode_q    <= mode_d;
      end
   end

   // ------------------------------------------------- scale and saturate
   sat_res_t              w_res;
   logic [DOUT_WIDTH-1:0] w_scaled;
   logic                  w_sat;
   logic                  w_unused_hi;

   always_comb begin
      w_res       = sat_shift(MAX_W'(product_q), mode_q, PROD_WIDTH,
                              DOUT_WIDTH, SHIFT);
      w_scaled    = w_res.value[DOUT_WIDTH-1:0];
      w_sat       = w_res.sat;
      // The container bits above DOUT_WIDTH are sign or zero copies after
      // saturation. Nothing reads them.
      w_unused_hi = ^w_res.value[MAX_W-1:DOUT_WIDTH];
   end

   pipe_delay #(
      .WIDTH (DOUT_WIDTH + 1),
      .DEPTH (OUT_REGS)
   ) u_out_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .din   ({w_sat, w_scaled}),
      .dout  ({dout_sat, dout})
   );

   // ----------------------------------------------------------- valid line
   pipe_delay #(
      .WIDTH (1),
      .DEPTH (LATENCY)
   ) u_valid_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din_valid),
      .dout  (dout_valid)
   );

endmodule
`default_nettype wire

// File: tb/tb_dsp48_mult_scaled.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dsp48_mult_scaled
// Description : Bench for dsp48_mult_scaled. It drives three configurations
//               from shared stimulus:
//                 dut0 - defaults (16x16 -> 32, SHIFT 0, L=4)
//                 dut1 - 16x16 -> 16, SHIFT 15, IN 1 / OUT 3 (L=5)
//                 dut2 - 12x10 -> 14, SHIFT 5,  IN 3 / OUT 3 (L=7)
//               Expected results are queued with their due cycle. A monitor
//               pops and compares them whenever dout_valid is high.
//               Honours DSP48_MULT_ROUND_EN in the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp48_mult_scaled;

   typedef struct {
      int          cyc;
      logic [31:0] val;
      logic        sat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] din1 = '0;
   logic [15:0] din2 = '0;
   logic        din_signed = 1'b0;
   logic        din_valid = 1'b0;

   logic [31:0] dout_0;
   logic [15:0] dout_1;
   logic [13:0] dout_2;
   logic        val_0, val_1, val_2;
   logic        sat_0, sat_1, sat_2;

   logic [31:0] act_d [3];
   logic        act_v [3];
   logic        act_s [3];

   int W1  [3] = '{16, 16, 12};
   int W2  [3] = '{16, 16, 10};
   int DW  [3] = '{32, 16, 14};
   int SH  [3] = '{0, 15, 5};
   int LAT [3] = '{4, 5, 7};

   exp_t q [3][$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

`ifdef DSP48_MULT_ROUND_EN
   localparam logic [31:0] EXP1_POS = 32'h0001;
   localparam logic [31:0] EXP1_NEG = 32'h0000;
`else
   localparam logic [31:0] EXP1_POS = 32'h0000;
   localparam logic [31:0] EXP1_NEG = 32'hFFFF;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dsp48_mult_scaled #(
      .DIN1_WIDTH(16), .DIN2_WIDTH(16), .DOUT_WIDTH(32),
      .SHIFT(0), .IN_REGS(2), .OUT_REGS(1)
   ) u_dut0 (
      .clk(clk), .rst_n(rst_n), .din1(din1), .din2(din2),
      .din_signed(din_signed), .din_valid(din_valid),
      .dout(dout_0), .dout_valid(val_0), .dout_sat(sat_0)
   );

   dsp48_mult_scaled #(
      .DIN1_WIDTH(16), .DIN2_WIDTH(16), .DOUT_WIDTH(16),
      .SHIFT(15), .IN_REGS(1), .OUT_REGS(3)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .din1(din1), .din2(din2),
      .din_signed(din_signed), .din_valid(din_valid),
      .dout(dout_1), .dout_valid(val_1), .dout_sat(sat_1)
   );

   dsp48_mult_scaled #(
      .DIN1_WIDTH(12), .DIN2_WIDTH(10), .DOUT_WIDTH(14),
      .SHIFT(5), .IN_REGS(3), .OUT_REGS(3)
   ) u_dut2 (
      .clk(clk), .rst_n(rst_n), .din1(din1[11:0]), .din2(din2[9:0]),
      .din_signed(din_signed), .din_valid(din_valid),
      .dout(dout_2), .dout_valid(val_2), .dout_sat(sat_2)
   );

   assign act_d[0] = dout_0;
   assign act_d[1] = {16'h0, dout_1};
   assign act_d[2] = {18'h0, dout_2};
   assign act_v[0] = val_0;
   assign act_v[1] = val_1;
   assign act_v[2] = val_2;
   assign act_s[0] = sat_0;
   assign act_s[1] = sat_1;
   assign act_s[2] = sat_2;

   // Reference model built from plain integer arithmetic. It returns
   // {sat, value}, with the value masked to the output width.
   function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic m, input int k);
      longint av, bv, p, r, hi, lo, mask;
      logic [31:0] v;
      logic        s;
      av = longint'({48'h0, a}) & ((longint'(1) << W1[k]) - 1);
      bv = longint'({48'h0, b}) & ((longint'(1) << W2[k]) - 1);
      if (m && av >= (longint'(1) << (W1[k] - 1))) av = av - (longint'(1) << W1[k]);
      if (m && bv >= (longint'(1) << (W2[k] - 1))) bv = bv - (longint'(1) << W2[k]);
      p = av * bv;
`ifdef DSP48_MULT_ROUND_EN
      if (SH[k] > 0) p = p + (longint'(1) << (SH[k] - 1));
`endif
      r    = p >>> SH[k];
      mask = (longint'(1) << DW[k]) - 1;
      hi   = m ? (longint'(1) << (DW[k] - 1)) - 1 : mask;
      lo   = m ? -(longint'(1) << (DW[k] - 1)) : 0;
      s    = 1'b1;
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
      else             s = 1'b0;
      v = 32'(r & mask);
      return {s, v};
   endfunction

   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic m);
      exp_t e;
      @(posedge clk);
      #1;
      din_valid  = v;
      din1       = a;
      din2       = b;
      din_signed = m;
      if (v) begin
         for (int k = 0; k < 3; k++) begin
            e.cyc = cyc + LAT[k];
            {e.sat, e.val} = model(a, b, m, k);
            q[k].push_back(e);
         end
      end
   endtask

   // Directed sample. Fixed expectations apply to dut0 and dut1; dut2
   // uses the model.
   task automatic drive_dir(input logic [15:0] a, input logic [15:0] b, input logic m,
                            input logic [31:0] e0, input logic s0,
                            input logic [31:0] e1, input logic s1);
      exp_t e;
      @(posedge clk);
      #1;
      din_valid  = 1'b1;
      din1       = a;
      din2       = b;
      din_signed = m;
      e.cyc = cyc + LAT[0]; e.val = e0; e.sat = s0; q[0].push_back(e);
      e.cyc = cyc + LAT[1]; e.val = e1; e.sat = s1; q[1].push_back(e);
      e.cyc = cyc + LAT[2];
      {e.sat, e.val} = model(a, b, m, 2);
      q[2].push_back(e);
   endtask

   task automatic chk_zero(input string name);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (act_d[k] != 32'h0 || act_v[k] || act_s[k]) begin
            errors++;
            $display("FAIL %s dut%0d: dout=%h valid=%b sat=%b, required all zero",
                     name, k, act_d[k], act_v[k], act_s[k]);
         end
      end
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 7))
         0:       return 16'h0000;
         1:       return 16'h7FFF;
         2:       return 16'h8000;
         3:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // Monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         if (act_v[k]) begin
            checks++;
            if (q[k].size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid dut%0d cyc=%0d dout=%h, required no output",
                        k, cyc, act_d[k]);
            end else begin
               e = q[k].pop_front();
               if (e.cyc != cyc || e.val != act_d[k] || e.sat != act_s[k]) begin
                  errors++;
                  $display("FAIL result dut%0d: got dout=%h sat=%b at cyc %0d, required dout=%h sat=%b at cyc %0d",
                           k, act_d[k], act_s[k], cyc, e.val, e.sat, e.cyc);
               end
            end
         end else if (rst_n) begin
            checks++;
            if (act_d[k] != 32'h0 || act_s[k]) begin
               errors++;
               $display("FAIL idle_zero dut%0d cyc=%0d: dout=%h sat=%b, required 0/0",
                        k, cyc, act_d[k], act_s[k]);
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset_state");
      rst_n = 1'b1;

      // Directed corner cases
      drive_dir(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b0, 32'h0000, 1'b0);
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      drive_dir(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b0, 32'hFFFF, 1'b1);
      drive_dir(16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b0, 32'h7FFF, 1'b1);
      drive_dir(16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001, 1'b0, 32'h7FFE, 1'b0);
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      drive_dir(16'h0001, 16'h4000, 1'b1, 32'h00004000, 1'b0, EXP1_POS, 1'b0);
      drive_dir(16'hFFFF, 16'h4000, 1'b1, 32'hFFFFC000, 1'b0, EXP1_NEG, 1'b0);
      repeat (10) drive(1'b0, 16'h0, 16'h0, 1'b0);

      // Random operands, modes and valid gaps
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), pick(), pick(), 1'($urandom_range(0, 1)));
      end
      repeat (10) drive(1'b0, 16'h0, 16'h0, 1'b0);

      // Reset in the middle of a valid stream
      for (int i = 0; i < 6; i++) drive(1'b1, pick(), pick(), 1'($urandom_range(0, 1)));
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      rst_n     = 1'b0;
      #1;
      chk_zero("reset_async");
      for (int k = 0; k < 3; k++) q[k].delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) drive(1'b1, pick(), pick(), 1'($urandom_range(0, 1)));
      repeat (12) drive(1'b0, 16'h0, 16'h0, 1'b0);

      for (int k = 0; k < 3; k++) begin
         checks++;
         if (q[k].size() != 0) begin
            errors++;
            $display("FAIL missing_output dut%0d: %0d expected results never appeared, required 0",
                     k, q[k].size());
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
